// File: rtl/a_plus_b_arb_pkg.sv
// Shared types and helpers for the a+b round-robin arbiter.
// Optional feature macro: A_PLUS_B_RR_ARBITER_CARRY_EN adds a carry bit to the output stage.
`timescale 1ns/1ps
package a_plus_b_arb_pkg;

  // Tag width for n requesters; never narrower than one bit.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

  // Default sizing of the arbiter; the output stage struct below is built from these.
  localparam int ARB_WIDTH = 8;
  localparam int ARB_N_REQ = 4;
  localparam int ARB_ID_W  = clog2_min1(ARB_N_REQ);

  // Single-entry output stage: the registered sum and the requester it belongs to.
  typedef struct packed {
    logic [ARB_WIDTH-1:0] data;
    logic [ARB_ID_W-1:0]  id;
`ifdef A_PLUS_B_RR_ARBITER_CARRY_EN
    logic                 carry;
`endif
  } sum_stage_t;

endpackage

// File: rtl/a_plus_b_rr_arbiter_rr_grant_select.sv
// Combinational round-robin grant selection: rotate the request vector so the
// pointer lands on bit 0, priority-encode the lowest set bit, then rotate the
// index back. Reusable by any pointer-based arbiter.
`timescale 1ns/1ps
module rr_grant_select #(
  parameter int n_req = 4,
  parameter int id_w  = 2
) (
  input  logic [n_req-1:0] req_valid,
  input  logic [id_w-1:0]  ptr,
  output logic [id_w-1:0]  grant,
  output logic             any_valid
);

  localparam logic [id_w:0] N_REQ_V = (id_w+1)'(n_req);

  logic [2*n_req-1:0] w_dbl;
  logic [n_req-1:0]   w_rot;
  logic [id_w-1:0]    w_offs;
  logic [id_w:0]      w_idx;

  // Doubling the vector makes a plain right shift behave as a rotate.
  assign w_dbl     = {req_valid, req_valid};
  assign w_rot     = n_req'(w_dbl >> ptr);
  assign any_valid = |req_valid;

  // Lowest set bit of the rotated vector is the distance from the pointer.
  always_comb begin
    w_offs = '0;
    for (int i = n_req - 1; i >= 0; i--) begin
      if (w_rot[i]) w_offs = id_w'(i);
    end
  end

  // Undo the rotation modulo n_req (n_req need not be a power of two).
  always_comb begin
    w_idx = {1'b0, ptr} + {1'b0, w_offs};
    if (w_idx >= N_REQ_V) begin
      grant = id_w'(w_idx - N_REQ_V);
    end else begin
      grant = id_w'(w_idx);
    end
  end

endmodule

// File: rtl/a_plus_b_rr_arbiter.sv
// Shares one a+b adder between n_req valid/ready requesters with round-robin
// grant and a single registered output stage tagged with the requester index.
// Optional feature macro: A_PLUS_B_RR_ARBITER_CARRY_EN adds output sum_carry.
// The output stage struct is sized by the package defaults (ARB_WIDTH, ARB_N_REQ);
// change those rather than overriding the parameters alone.
`timescale 1ns/1ps
module a_plus_b_rr_arbiter
  import a_plus_b_arb_pkg::*;
#(
  parameter int width = ARB_WIDTH,
  parameter int n_req = ARB_N_REQ,
  parameter int id_w  = clog2_min1(n_req)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [n_req-1:0]       req_valid,
  output logic [n_req-1:0]       req_ready,
  input  logic [n_req*width-1:0] req_a,
  input  logic [n_req*width-1:0] req_b,
  output logic                   sum_valid,
  input  logic                   sum_ready,
  output logic [width-1:0]       sum_data,
  output logic [id_w-1:0]        sum_id
`ifdef A_PLUS_B_RR_ARBITER_CARRY_EN
  , output logic                 sum_carry
`endif
);

  logic              r_valid;
  sum_stage_t        r_out;
  logic [id_w-1:0]   r_ptr;

  logic              w_load_en;
  logic              w_any;
  logic              w_take;
  logic [id_w-1:0]   w_grant;
  logic [id_w-1:0]   w_ptr_next;
  logic [width-1:0]  w_a_arr [n_req];
  logic [width-1:0]  w_b_arr [n_req];
  logic [width-1:0]  w_a;
  logic [width-1:0]  w_b;
  logic [width-1:0]  w_sum;

  rr_grant_select #(
    .n_req (n_req),
    .id_w  (id_w)
  ) u_sel (
    .req_valid (req_valid),
    .ptr       (r_ptr),
    .grant     (w_grant),
    .any_valid (w_any)
  );

  // Unpack the per-requester operand lanes.
  genvar gi;
  generate
    for (gi = 0; gi < n_req; gi++) begin : g_lane
      assign w_a_arr[gi] = req_a[gi*width +: width];
      assign w_b_arr[gi] = req_b[gi*width +: width];
    end
  endgenerate

  // The output stage can take a new result when empty or draining this cycle.
  assign w_load_en  = ~r_valid | sum_ready;
  assign w_take     = w_load_en & w_any;
  assign w_a        = w_a_arr[w_grant];
  assign w_b        = w_b_arr[w_grant];
  assign w_ptr_next = (w_grant == id_w'(n_req - 1)) ? '0 : w_grant + 1'b1;

`ifdef A_PLUS_B_RR_ARBITER_CARRY_EN
  logic [width:0]    w_full;
  assign w_full = {1'b0, w_a} + {1'b0, w_b};
  assign w_sum  = w_full[width-1:0];
`else
  assign w_sum  = w_a + w_b;
`endif

  // Only the selected requester sees ready, and only when the stage can load.
  always_comb begin
    req_ready = '0;
    if (w_take) req_ready[w_grant] = 1'b1;
  end

  // Output stage and round-robin pointer; the pointer moves only on a transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_out   <= '0;
      r_ptr   <= '0;
    end else if (w_load_en) begin
      r_valid <= w_any;
      if (w_any) begin
        r_out.data  <= w_sum;
        r_out.id    <= w_grant;
`ifdef A_PLUS_B_RR_ARBITER_CARRY_EN
        r_out.carry <= w_full[width];
`endif
        r_ptr       <= w_ptr_next;
      end
    end
  end

  assign sum_valid = r_valid;
  assign sum_data  = r_out.data;
  assign sum_id    = r_out.id;
`ifdef A_PLUS_B_RR_ARBITER_CARRY_EN
  assign sum_carry = r_out.carry;
`endif

endmodule

// File: tb/tb_a_plus_b_rr_arbiter.sv
// Directed bench for a_plus_b_rr_arbiter (width=8, n_req=4).
// Inputs change #1 after posedge; outputs are sampled on the negedge.
`timescale 1ns/1ps
module tb_a_plus_b_rr_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        sum_valid;
  logic        sum_ready;
  logic [7:0]  sum_data;
  logic [1:0]  sum_id;
`ifdef A_PLUS_B_RR_ARBITER_CARRY_EN
  logic        sum_carry;
`endif

  int n_total;
  int n_bad;

  a_plus_b_rr_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .sum_valid (sum_valid),
    .sum_ready (sum_ready),
    .sum_data  (sum_data),
    .sum_id    (sum_id)
`ifdef A_PLUS_B_RR_ARBITER_CARRY_EN
    , .sum_carry (sum_carry)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b);
    req_a[i*8 +: 8] = a;
    req_b[i*8 +: 8] = b;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  int exp_g [7] = '{1, 3, 1, 3, 0, 1, 3};
  logic [7:0] fair_sum [4] = '{8'd7, 8'd11, 8'd0, 8'd33};

  initial begin
    n_total   = 0;
    n_bad     = 0;
    rst       = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    sum_ready = 1'b1;

    // Reset state
    @(negedge clk);
    check_val("rst_sum_valid", 32'(sum_valid), 0);
    check_val("rst_sum_data",  32'(sum_data),  0);
    check_val("rst_sum_id",    32'(sum_id),    0);
    tick();
    rst = 1'b0;

    // Single requester 2: 3+5
    set_op(2, 8'd3, 8'd5);
    req_valid = 4'b0100;
    @(negedge clk);
    check_val("single_ready", 32'(req_ready), 32'h4);
    tick();
    req_valid = '0;
    @(negedge clk);
    check_val("single_valid", 32'(sum_valid), 1);
    check_val("single_data",  32'(sum_data),  8);
    check_val("single_id",    32'(sum_id),    2);
    @(negedge clk);
    check_val("single_drain", 32'(sum_valid), 0);

    // All four valid, continuous sum_ready: sums 3,20,37,54
    do_reset();
    for (int i = 0; i < 4; i++) set_op(i, 8'(16*i + 1), 8'(i + 2));
    req_valid = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check_val($sformatf("rr_ready_%0d", c), 32'(req_ready), 32'(1 << (c % 4)));
      if (c > 0) begin
        check_val($sformatf("rr_id_%0d", c),   32'(sum_id),   32'((c - 1) % 4));
        check_val($sformatf("rr_data_%0d", c), 32'(sum_data), 32'(17*((c - 1) % 4) + 3));
      end
    end

    // Backpressure: requester 3 result (54) held for 5 cycles
    tick();
    sum_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check_val($sformatf("bp_valid_%0d", c), 32'(sum_valid), 1);
      check_val($sformatf("bp_id_%0d", c),    32'(sum_id),    3);
      check_val($sformatf("bp_data_%0d", c),  32'(sum_data),  54);
      check_val($sformatf("bp_ready_%0d", c), 32'(req_ready), 0);
    end
    sum_ready = 1'b1;
    #1;
    check_val("bp_release_ready", 32'(req_ready), 32'h1);
    @(negedge clk);
    check_val("bp_release_id",   32'(sum_id),   0);
    check_val("bp_release_data", 32'(sum_data), 3);
    req_valid = '0;

    // Wrap-around arithmetic
    do_reset();
    set_op(1, 8'd200, 8'd100);
    req_valid = 4'b0010;
    tick();
    req_valid = '0;
    @(negedge clk);
    check_val("wrap1_data", 32'(sum_data), 44);
    check_val("wrap1_id",   32'(sum_id),   1);
`ifdef A_PLUS_B_RR_ARBITER_CARRY_EN
    check_val("wrap1_carry", 32'(sum_carry), 1);
`endif
    set_op(0, 8'd255, 8'd1);
    req_valid = 4'b0001;
    tick();
    req_valid = '0;
    @(negedge clk);
    check_val("wrap2_data", 32'(sum_data), 0);
    check_val("wrap2_id",   32'(sum_id),   0);
`ifdef A_PLUS_B_RR_ARBITER_CARRY_EN
    check_val("wrap2_carry", 32'(sum_carry), 1);
`endif
    set_op(2, 8'd1, 8'd2);
    req_valid = 4'b0100;
    tick();
    req_valid = '0;
    @(negedge clk);
    check_val("wrap3_data", 32'(sum_data), 3);
    check_val("wrap3_id",   32'(sum_id),   2);
`ifdef A_PLUS_B_RR_ARBITER_CARRY_EN
    check_val("wrap3_carry", 32'(sum_carry), 0);
`endif

    // Fairness with sparse requests; requester 0 joins while 3 is granted
    do_reset();
    set_op(0, 8'd7, 8'd0);
    set_op(1, 8'd10, 8'd1);
    set_op(3, 8'd30, 8'd3);
    req_valid = 4'b1010;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      check_val($sformatf("fair_ready_%0d", k), 32'(req_ready), 32'(1 << exp_g[k]));
      if (k > 0) begin
        check_val($sformatf("fair_id_%0d", k),   32'(sum_id),   32'(exp_g[k-1]));
        check_val($sformatf("fair_data_%0d", k), 32'(sum_data), 32'(fair_sum[exp_g[k-1]]));
      end
      if (k == 3) req_valid[0] = 1'b1;
    end

    // Asynchronous reset mid-cycle with a result pending (pointer would pick 3)
    req_valid[0] = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check_val("arst_valid", 32'(sum_valid), 0);
    check_val("arst_data",  32'(sum_data),  0);
    check_val("arst_id",    32'(sum_id),    0);
    check_val("arst_ready", 32'(req_ready), 32'h2);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_val("post_rst_id",    32'(sum_id),    1);
    check_val("post_rst_data",  32'(sum_data),  11);
    check_val("post_rst_ready", 32'(req_ready), 32'h8);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
